// File: rtl/count_chk_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : count_chk_pkg
//  Description : Shared types and constants for the count sequence checker.
//                Holds the checker state, the per-sample step class and the
//                candidate counting direction.
//  Revision    : 1.0  initial release
// ============================================================================
package count_chk_pkg;

    // Width of the consecutive-step run counter; covers LOCK_LEN up to 15.
    localparam int unsigned c_run_w = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ACQUIRE   = 2'd1,
        LOCK_UP   = 2'd2,
        LOCK_DOWN = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        STEP_HOLD = 2'd0,
        STEP_UP   = 2'd1,
        STEP_DOWN = 2'd2,
        STEP_BAD  = 2'd3
    } step_t;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DOWN = 2'd2
    } dir_t;

endpackage : count_chk_pkg
`default_nettype wire

// File: rtl/count_step_classify.sv
`default_nettype none
// ============================================================================
//  Module      : count_step_classify
//  Description : Combinational classifier for one sample-to-sample step of
//                an observed counter. delta = (i_count - i_prev) mod 2^WIDTH.
//  Ports       : i_prev   - previously sampled count
//                i_count  - newly sampled count
//                o_step   - HOLD / UP / DOWN / BAD
//                o_wrap   - step crosses the max<->0 boundary in its direction
//  Revision    : 1.0  initial release
// ============================================================================
module count_step_classify
    import count_chk_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_prev,
    input  logic [WIDTH-1:0] i_count,
    output step_t            o_step,
    output logic             o_wrap
);

    logic [WIDTH-1:0] w_delta;

    always_comb begin
        w_delta = i_count - i_prev;
        o_step  = STEP_BAD;
        o_wrap  = 1'b0;
        if (w_delta == '0) begin
            o_step = STEP_HOLD;
        end else if (w_delta == WIDTH'(1)) begin
            // Up step landing on zero means prev was max.
            o_step = STEP_UP;
            o_wrap = (i_count == '0);
        end else if (w_delta == '1) begin
            // Down step landing on max means prev was zero.
            o_step = STEP_DOWN;
            o_wrap = (i_count == '1);
        end
    end

endmodule : count_step_classify
`default_nettype wire

// File: rtl/count_sequence_checker.sv
`default_nettype none
// ============================================================================
//  Module      : count_sequence_checker
//  Description : Receive-side monitor for an up/down counter. Classifies each
//                sampled step, locks onto a direction after LOCK_LEN
//                consistent steps, then flags violations and wraps.
//  Ports       : clk        - clock, rising edge
//                reset      - asynchronous active-low reset
//                sample_en  - count_in valid this cycle
//                count_in   - observed counter value
//                clr_err    - synchronous clear of err_count
//                locked     - in LOCK_UP or LOCK_DOWN
//                dir_up     - in LOCK_UP
//                dir_down   - in LOCK_DOWN
//                seq_error  - one-cycle pulse on a violation while locked
//                wrap_pulse - one-cycle pulse on a locked wrap
//                err_count  - saturating violation count
//  Revision    : 1.0  initial release
// ============================================================================
module count_sequence_checker
    import count_chk_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int LOCK_LEN = 2,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sample_en,
    input  logic [WIDTH-1:0] count_in,
    input  logic             clr_err,
    output logic             locked,
    output logic             dir_up,
    output logic             dir_down,
    output logic             seq_error,
    output logic             wrap_pulse,
    output logic [ERR_W-1:0] err_count
);

    localparam logic [c_run_w-1:0] c_lock_len = c_run_w'(LOCK_LEN);
    localparam logic [c_run_w-1:0] c_run_one  = c_run_w'(1);
    localparam logic [ERR_W-1:0]   c_err_one  = ERR_W'(1);

    state_t             r_state_q, w_state_d;
    logic [WIDTH-1:0]   r_prev_q,  w_prev_d;
    logic [c_run_w-1:0] r_run_q,   w_run_d;
    dir_t               r_cand_q,  w_cand_d;
    logic               r_seq_q,   w_seq_d;
    logic               r_wrap_q,  w_wrap_d;
    logic [ERR_W-1:0]   r_err_q,   w_err_d;
    logic [ERR_W-1:0]   w_err_base;

    step_t              w_step;
    logic               w_wrap;

    count_step_classify #(
        .WIDTH (WIDTH)
    ) u_classify (
        .i_prev  (r_prev_q),
        .i_count (count_in),
        .o_step  (w_step),
        .o_wrap  (w_wrap)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d = r_state_q;
        w_prev_d  = r_prev_q;
        w_run_d   = r_run_q;
        w_cand_d  = r_cand_q;
        w_seq_d   = 1'b0;
        w_wrap_d  = 1'b0;

        if (sample_en) begin
            w_prev_d = count_in;
            unique case (r_state_q)
                IDLE: begin
                    // First sample only establishes a reference.
                    w_state_d = ACQUIRE;
                    w_run_d   = '0;
                    w_cand_d  = DIR_NONE;
                end

                ACQUIRE: begin
                    unique case (w_step)
                        STEP_UP: begin
                            if (r_cand_q == DIR_UP) begin
                                w_run_d = r_run_q + c_run_one;
                            end else begin
                                w_cand_d = DIR_UP;
                                w_run_d  = c_run_one;
                            end
                            if (w_run_d >= c_lock_len) w_state_d = LOCK_UP;
                        end
                        STEP_DOWN: begin
                            if (r_cand_q == DIR_DOWN) begin
                                w_run_d = r_run_q + c_run_one;
                            end else begin
                                w_cand_d = DIR_DOWN;
                                w_run_d  = c_run_one;
                            end
                            if (w_run_d >= c_lock_len) w_state_d = LOCK_DOWN;
                        end
                        STEP_BAD: begin
                            w_run_d  = '0;
                            w_cand_d = DIR_NONE;
                        end
                        default: ;  // HOLD: nothing changes
                    endcase
                end

                LOCK_UP: begin
                    unique case (w_step)
                        STEP_UP: w_wrap_d = w_wrap;
                        STEP_DOWN: begin
                            // Reversal counts as the first step of a new run;
                            // with LOCK_LEN=1 that already relocks downwards.
                            w_seq_d   = 1'b1;
                            w_cand_d  = DIR_DOWN;
                            w_run_d   = c_run_one;
                            w_state_d = (c_run_one >= c_lock_len) ? LOCK_DOWN : ACQUIRE;
                        end
                        STEP_BAD: begin
                            w_seq_d   = 1'b1;
                            w_cand_d  = DIR_NONE;
                            w_run_d   = '0;
                            w_state_d = ACQUIRE;
                        end
                        default: ;  // HOLD: stay locked
                    endcase
                end

                LOCK_DOWN: begin
                    unique case (w_step)
                        STEP_DOWN: w_wrap_d = w_wrap;
                        STEP_UP: begin
                            w_seq_d   = 1'b1;
                            w_cand_d  = DIR_UP;
                            w_run_d   = c_run_one;
                            w_state_d = (c_run_one >= c_lock_len) ? LOCK_UP : ACQUIRE;
                        end
                        STEP_BAD: begin
                            w_seq_d   = 1'b1;
                            w_cand_d  = DIR_NONE;
                            w_run_d   = '0;
                            w_state_d = ACQUIRE;
                        end
                        default: ;
                    endcase
                end

                default: w_state_d = IDLE;
            endcase
        end

        // Clear takes effect before the increment, so clear+error yields 1.
        w_err_base = clr_err ? '0 : r_err_q;
        if (w_seq_d && (w_err_base != '1)) begin
            w_err_d = w_err_base + c_err_one;
        end else begin
            w_err_d = w_err_base;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state_q <= IDLE;
            r_prev_q  <= '0;
            r_run_q   <= '0;
            r_cand_q  <= DIR_NONE;
            r_seq_q   <= 1'b0;
            r_wrap_q  <= 1'b0;
            r_err_q   <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_prev_q  <= w_prev_d;
            r_run_q   <= w_run_d;
            r_cand_q  <= w_cand_d;
            r_seq_q   <= w_seq_d;
            r_wrap_q  <= w_wrap_d;
            r_err_q   <= w_err_d;
        end
    end

    assign locked     = (r_state_q == LOCK_UP) || (r_state_q == LOCK_DOWN);
    assign dir_up     = (r_state_q == LOCK_UP);
    assign dir_down   = (r_state_q == LOCK_DOWN);
    assign seq_error  = r_seq_q;
    assign wrap_pulse = r_wrap_q;
    assign err_count  = r_err_q;

endmodule : count_sequence_checker
`default_nettype wire

// File: tb/tb_count_sequence_checker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_count_sequence_checker
//  Description : Self-checking bench for count_sequence_checker. A second
//                instance with LOCK_LEN=1 shares the stimulus and is checked
//                only at the immediate-relock scenario.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_count_sequence_checker;

    localparam int WIDTH    = 4;
    localparam int LOCK_LEN = 2;
    localparam int ERR_W    = 8;
    localparam int c_max    = (1 << WIDTH) - 1;
    localparam int c_err_max = (1 << ERR_W) - 1;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             sample_en;
    logic [WIDTH-1:0] count_in;
    logic             clr_err;

    logic             locked, dir_up, dir_down, seq_error, wrap_pulse;
    logic [ERR_W-1:0] err_count;
    logic             l1_locked, l1_dir_up, l1_dir_down, l1_seq_error, l1_wrap_pulse;
    logic [ERR_W-1:0] l1_err_count;

    always #5 clk = ~clk;

    count_sequence_checker #(
        .WIDTH    (WIDTH),
        .LOCK_LEN (LOCK_LEN),
        .ERR_W    (ERR_W)
    ) dut (
        .clk        (clk),
        .reset      (reset_n),
        .sample_en  (sample_en),
        .count_in   (count_in),
        .clr_err    (clr_err),
        .locked     (locked),
        .dir_up     (dir_up),
        .dir_down   (dir_down),
        .seq_error  (seq_error),
        .wrap_pulse (wrap_pulse),
        .err_count  (err_count)
    );

    count_sequence_checker #(
        .WIDTH    (WIDTH),
        .LOCK_LEN (1),
        .ERR_W    (ERR_W)
    ) dut_l1 (
        .clk        (clk),
        .reset      (reset_n),
        .sample_en  (sample_en),
        .count_in   (count_in),
        .clr_err    (clr_err),
        .locked     (l1_locked),
        .dir_up     (l1_dir_up),
        .dir_down   (l1_dir_down),
        .seq_error  (l1_seq_error),
        .wrap_pulse (l1_wrap_pulse),
        .err_count  (l1_err_count)
    );

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: directions as signed ints (+1 up, -1 down, 0 none),
    // step sizes from modular integer arithmetic.
    // ------------------------------------------------------------------
    bit m_have;     // a reference sample exists
    int m_prev;
    int m_cand;     // candidate direction
    int m_run;      // consecutive steps in candidate direction
    int m_lock;     // locked direction, 0 if unlocked
    bit m_seq, m_wrap;
    int m_err;

    function automatic void model_reset();
        m_have = 1'b0; m_prev = 0; m_cand = 0; m_run = 0; m_lock = 0;
        m_seq = 1'b0; m_wrap = 1'b0; m_err = 0;
    endfunction

    function automatic void model_step(input bit en, input int v, input bit clr);
        int d;
        int s;      // +1, -1, 0 hold, 2 bad
        m_seq  = 1'b0;
        m_wrap = 1'b0;
        if (en) begin
            if (!m_have) begin
                m_have = 1'b1; m_cand = 0; m_run = 0; m_lock = 0;
            end else begin
                d = (v - m_prev + c_max + 1) % (c_max + 1);
                if (d == 0)          s = 0;
                else if (d == 1)     s = 1;
                else if (d == c_max) s = -1;
                else                 s = 2;
                if (m_lock != 0) begin
                    if (s == m_lock) begin
                        m_wrap = (m_lock == 1) ? (m_prev == c_max && v == 0)
                                               : (m_prev == 0 && v == c_max);
                    end else if (s != 0) begin
                        m_seq  = 1'b1;
                        m_lock = 0;
                        if (s == 2) begin
                            m_cand = 0; m_run = 0;
                        end else begin
                            m_cand = s; m_run = 1;
                            if (m_run >= LOCK_LEN) m_lock = s;
                        end
                    end
                end else if (s == 2) begin
                    m_cand = 0; m_run = 0;
                end else if (s != 0) begin
                    m_run  = (m_cand == s) ? m_run + 1 : 1;
                    m_cand = s;
                    if (m_run >= LOCK_LEN) m_lock = s;
                end
            end
            m_prev = v;
        end
        if (clr) m_err = 0;
        if (m_seq && m_err < c_err_max) m_err++;
    endfunction

    task automatic compare_all(input string tag);
        check_val({tag, ".locked"},    32'(locked),     32'(m_lock != 0));
        check_val({tag, ".dir_up"},    32'(dir_up),     32'(m_lock == 1));
        check_val({tag, ".dir_down"},  32'(dir_down),   32'(m_lock == -1));
        check_val({tag, ".seq_error"}, 32'(seq_error),  32'(m_seq));
        check_val({tag, ".wrap"},      32'(wrap_pulse), 32'(m_wrap));
        check_val({tag, ".err_count"}, 32'(err_count),  32'(m_err));
    endtask

    // Apply one cycle of stimulus at the falling edge, check after rising edge.
    task automatic step(input bit en, input int v, input bit clr, input string tag);
        @(negedge clk);
        sample_en = en;
        count_in  = WIDTH'(v & c_max);
        clr_err   = clr;
        model_step(en, v & c_max, clr);
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n   = 1'b0;
        sample_en = 1'b0;
        clr_err   = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_val("reset.outputs",
                  32'({locked, dir_up, dir_down, seq_error, wrap_pulse, err_count}), 32'd0);
        compare_all("reset");
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n   = 1'b0;
        sample_en = 1'b0;
        count_in  = '0;
        clr_err   = 1'b0;
        model_reset();

        // Lock up on 3,4,5
        do_reset();
        step(1, 3, 0, "lockup");
        step(1, 4, 0, "lockup");
        check_val("lockup.not_yet", 32'(locked), 32'd0);
        step(1, 5, 0, "lockup");
        check_val("lockup.locked", 32'(locked), 32'd1);
        check_val("lockup.dir_up", 32'(dir_up), 32'd1);

        // Up wrap 14,15,0
        do_reset();
        step(1, 12, 0, "upwrap");
        step(1, 13, 0, "upwrap");
        step(1, 14, 0, "upwrap");
        step(1, 15, 0, "upwrap");
        check_val("upwrap.early", 32'(wrap_pulse), 32'd0);
        step(1, 0, 0, "upwrap");
        check_val("upwrap.pulse", 32'(wrap_pulse), 32'd1);
        step(1, 1, 0, "upwrap");
        check_val("upwrap.once", 32'(wrap_pulse), 32'd0);
        check_val("upwrap.err", 32'(err_count), 32'd0);

        // Down lock and wrap
        do_reset();
        step(1, 2, 0, "dnwrap");
        step(1, 1, 0, "dnwrap");
        step(1, 0, 0, "dnwrap");
        check_val("dnwrap.dir_down", 32'(dir_down), 32'd1);
        step(1, 15, 0, "dnwrap");
        check_val("dnwrap.pulse", 32'(wrap_pulse), 32'd1);

        // Violation and relock
        do_reset();
        step(1, 4, 0, "viol");
        step(1, 5, 0, "viol");
        step(1, 6, 0, "viol");
        step(1, 9, 0, "viol");
        check_val("viol.seq", 32'(seq_error), 32'd1);
        check_val("viol.err", 32'(err_count), 32'd1);
        check_val("viol.unlocked", 32'(locked), 32'd0);
        step(1, 10, 0, "viol");
        step(1, 11, 0, "viol");
        check_val("viol.relock", 32'(dir_up), 32'd1);
        check_val("viol.err_kept", 32'(err_count), 32'd1);

        // Reversal, holds and idle cycles
        do_reset();
        step(1, 5, 0, "rev");
        step(1, 6, 0, "rev");
        step(1, 7, 0, "rev");
        step(1, 6, 0, "rev");
        check_val("rev.seq", 32'(seq_error), 32'd1);
        step(1, 5, 0, "rev");
        check_val("rev.dir_down", 32'(dir_down), 32'd1);
        for (int i = 0; i < 4; i++) step(0, $urandom_range(0, c_max), 0, "rev.idle");
        step(1, 5, 0, "rev.hold");
        step(1, 5, 0, "rev.hold");
        check_val("rev.still_down", 32'(dir_down), 32'd1);
        step(1, 4, 0, "rev.cont");
        check_val("rev.no_err", 32'(seq_error), 32'd0);

        // LOCK_LEN=1 instance: immediate lock and same-edge relock
        do_reset();
        step(1, 3, 0, "l1");
        step(1, 4, 0, "l1");
        check_val("l1.lock_up", 32'(l1_dir_up), 32'd1);
        step(1, 3, 0, "l1");
        check_val("l1.seq", 32'(l1_seq_error), 32'd1);
        check_val("l1.relock_down", 32'(l1_dir_down), 32'd1);
        check_val("l1.err", 32'(l1_err_count), 32'd1);

        // Saturation: one violation per two samples
        do_reset();
        step(1, 0, 0, "sat");
        step(1, 1, 0, "sat");
        step(1, 2, 0, "sat");
        for (int i = 0; i < 600; i++) begin
            int dlt;
            dlt = (((i / 2) % 2) == 0) ? -1 : 1;
            step(1, m_prev + dlt + c_max + 1, 0, "sat");
        end
        check_val("sat.err", 32'(err_count), 32'(c_err_max));
        step(1, m_prev + 5, 1, "sat.clr");
        check_val("sat.clr_err", 32'(err_count), 32'd1);
        step(0, 0, 1, "sat.clr_only");
        check_val("sat.cleared", 32'(err_count), 32'd0);

        // Asynchronous reset while locked
        step(1, m_prev + 1, 0, "arst");
        step(1, m_prev + 1, 0, "arst");
        check_val("arst.pre_locked", 32'(locked), 32'd1);
        @(negedge clk);
        sample_en = 1'b0;
        clr_err   = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check_val("arst.immediate",
                  32'({locked, dir_up, dir_down, seq_error, wrap_pulse, err_count}), 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        step(1, 7, 0, "arst.resume");
        step(1, 8, 0, "arst.resume");
        check_val("arst.no_memory", 32'(locked), 32'd0);
        step(1, 9, 0, "arst.resume");

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            int r, v;
            bit en, clr;
            r   = $urandom_range(0, 9);
            en  = ($urandom_range(0, 9) != 0);
            clr = ($urandom_range(0, 24) == 0);
            if (r < 4)      v = m_prev + 1;
            else if (r < 7) v = m_prev + c_max;
            else if (r < 8) v = m_prev;
            else            v = $urandom_range(0, c_max);
            step(en, v, clr, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule : tb_count_sequence_checker
`default_nettype wire
